jkff_cmd_arbiter: RTL and testbench
===================================

# jkff_cmd_arbiter

Round-robin command arbiter that shares one external `jkff` instance between `N_REQ` requesters. Each requester posts a hold/reset/set/toggle command; the arbiter grants one at a time, drives the flip-flop's `j`/`k` for exactly one cycle, samples the resulting `q`, and returns it to the winner. It sits directly in front of `jkff` and is the only driver of its `j`/`k` inputs.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default `$clog2(N_REQ)`: width of the requester index; derived, not overridden.

- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request, level.
- `cmd`  in  2*N_REQ  per-requester command; bits [2i+1:2i] belong to requester i. 00 hold, 01 reset, 10 set, 11 toggle.
- `gnt`  out  N_REQ  one-hot grant pulse, registered.
- `j`  out  1  to `jkff.j`, registered.
- `k`  out  1  to `jkff.k`, registered.
- `q`  in  1  from `jkff.q`.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_id`  out  IDW  index of the requester being answered.
- `rsp_q`  out  1  `q` value after the command took effect.
- `busy`  out  1  high while a transaction is in flight.
- `err`  out  1  sticky mismatch flag; see Configuration.

## Operation
- FSM states: IDLE, DRIVE, SAMPLE. Reset state IDLE.
- IDLE: if `req` != 0 at a rising edge, pick the winner by round robin, latch its `cmd` and index, and go to DRIVE. Otherwise stay in IDLE.
- DRIVE: `gnt[winner]`=1. `j`/`k` are driven from the latched command: hold 0/0, reset 0/1, set 1/0, toggle 1/1. The old `q` is captured at the end of DRIVE. Next state is SAMPLE.
- SAMPLE: `j`=`k`=0 and `gnt`=0. The new `q` is sampled at the end of SAMPLE. Next state is IDLE. In the following cycle `rsp_valid`=1, `rsp_q` = the sampled `q`, and `rsp_id` = the winner.
- Round robin: pointer `ptr` starts at 0 after reset. The search order is `ptr`, `ptr+1`, …, wrapping modulo `N_REQ`. After a grant, `ptr` = winner+1 (mod `N_REQ`).
- `req`/`cmd` are ignored in DRIVE and SAMPLE. No new grant is possible before the IDLE edge following SAMPLE.
- Requester rule: hold `req` and `cmd` stable until `gnt` is seen. Drop `req` no later than the cycle after `gnt`. A `req` still high at the next IDLE edge counts as a new request.
- A hold command is a full transaction: j=k=0 and the unchanged `q` is returned.
- `busy` = (state != IDLE), decoded from the state register.
- `rsp_id` and `rsp_q` hold their last values between responses.

## Timing
- Edge E0 (IDLE, `req` seen): the cycle after E0 has `gnt`, `j`, `k` valid and `busy`=1.
- Edge E1: `jkff` captures `j`/`k`. The FSM enters SAMPLE and `j`/`k` return to 0.
- Edge E2: the FSM samples `q` and returns to IDLE. The cycle after E2 has `rsp_valid`=1 and `busy`=0.
- Next possible grant decision is at E3. Peak throughput is one command per 3 cycles.
- `j`/`k` are never nonzero outside DRIVE, and never nonzero for more than 1 cycle per grant.
- Reset, asynchronous at any point:
  - state goes to IDLE and `ptr` to 0;
  - `gnt`, `j`, `k`, `rsp_valid`, `rsp_id`, `rsp_q`, `busy`, `err` all go to 0;
  - any in-flight transaction is dropped with no response;
  - `jkff` itself is not reset by this block.

## Configuration
- Macro `JKFF_ARB_CHECK_EN`.
- Defined: the expected value is computed from the captured old `q` and the latched command (hold keeps `q`, reset gives 0, set gives 1, toggle gives ~old `q`). It is compared against the sampled `q` at E2. On a mismatch, `err` is set in the response cycle and stays high until reset.
- Undefined: the check logic is not compiled and `err` is tied to 0. The port list is identical in both builds.

## Test plan
- Reset, then `req`=0001 with `cmd[1:0]`=10. Required: `gnt`=0001 and j=1/k=0 for 1 cycle; `rsp_valid` with `rsp_id`=0 and `rsp_q`=1 two cycles later.
- Starting from `q`=1, requester 2 issues toggle (11), then a second toggle. Required: `rsp_q`=0, then 1; `busy` high for exactly 2 of every 3 cycles.
- `req`=1111 held continuously after reset, each requester dropping `req` after its grant. Required: grant order 0,1,2,3, with grants 3 cycles apart.
- `req`=0110 and `ptr`=3 (after a requester-2 grant, with requester 3 idle). Required: the search starts at 3, giving grant to requester 1, then to requester 2.
- Assert `rst_n`=0 during DRIVE. Required: `j`, `k`, `gnt`, `busy` go to 0 immediately; no `rsp_valid` is produced; the next request from requester 0 is granted first.
- With `JKFF_ARB_CHECK_EN` defined, force `q` stuck at 0 and issue set. Required: `err`=1 in the response cycle and it remains 1 until reset. Without the macro, `err` stays 0.

Source files
------------

// File: rtl/jkff_cmd_arbiter.sv
// Round-robin arbiter that shares one external JK flip-flop between N_REQ command requesters.
// Define JKFF_ARB_CHECK_EN to compile the response self-check that drives the sticky err flag.
module jkff_cmd_arbiter #(
  parameter int  N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] cmd,
  output logic [N_REQ-1:0]   gnt,
  output logic               j,
  output logic               k,
  input  logic               q,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_q,
  output logic               busy,
  output logic               err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;

  logic [1:0]       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_win;
  logic [N_REQ-1:0] r_gnt;
  logic             r_j;
  logic             r_k;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_q;

  logic [N_REQ-1:0][1:0] w_cmd_v;
  logic                  w_found;
  logic [IDW-1:0]        w_cand;
  logic [IDW-1:0]        w_win;
  logic [IDW-1:0]        w_ptr_nxt;
  logic [1:0]            w_win_cmd;
  logic                  w_start;

  assign w_cmd_v = cmd;

  // First requesting index at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = r_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = IDW'((int'(r_ptr) + i) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  assign w_win_cmd = w_cmd_v[w_win];
  assign w_ptr_nxt = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + IDW'(1);
  assign w_start   = (r_state == S_IDLE) && w_found;

  // The command encoding maps straight onto j/k: hold 00, reset 01, set 10, toggle 11.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_gnt       <= '0;
      r_j         <= 1'b0;
      r_k         <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_DRIVE;
            r_win   <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= N_REQ'(1) << w_win;
            r_j     <= w_win_cmd[1];
            r_k     <= w_win_cmd[0];
          end
        end
        S_DRIVE: begin
          r_state <= S_SAMPLE;
          r_gnt   <= '0;
          r_j     <= 1'b0;
          r_k     <= 1'b0;
        end
        S_SAMPLE: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_win;
          r_rsp_q     <= q;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_j     <= 1'b0;
          r_k     <= 1'b0;
        end
      endcase
    end
  end

`ifdef JKFF_ARB_CHECK_EN
  logic [1:0] r_cmd;
  logic       r_old_q;
  logic       r_err;
  logic       w_exp_q;

  always_comb begin
    case (r_cmd)
      2'b00:   w_exp_q = r_old_q;
      2'b01:   w_exp_q = 1'b0;
      2'b10:   w_exp_q = 1'b1;
      default: w_exp_q = ~r_old_q;
    endcase
  end

  // Old q is taken at the edge where the flip-flop captures j/k, so it is the pre-command value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd   <= 2'b00;
      r_old_q <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_cmd <= w_win_cmd;
      end
      if (r_state == S_DRIVE) begin
        r_old_q <= q;
      end
      if ((r_state == S_SAMPLE) && (q != w_exp_q)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign gnt       = r_gnt;
  assign j         = r_j;
  assign k         = r_k;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_q     = r_rsp_q;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_jkff_cmd_arbiter.sv
// Scoreboard bench for jkff_cmd_arbiter with a behavioural JK flip-flop on j/k/q.
module tb_jkff_cmd_arbiter;
  localparam int N = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req   = '0;
  logic [N-1:0][1:0] cmd_v = '0;
  logic [2*N-1:0]  cmd;
  logic [N-1:0]    gnt;
  logic            j, k, q;
  logic            rsp_valid, rsp_q, busy, err;
  logic [1:0]      rsp_id;

  logic q_ff  = 1'b0;
  logic stuck = 1'b0;
  logic m_q   = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct packed { logic [1:0] id; logic q; } exp_t;
  exp_t sb[$];

  assign cmd = cmd_v;
  assign q   = stuck ? 1'b0 : q_ff;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end

  jkff_cmd_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .gnt(gnt), .j(j), .k(k), .q(q),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [1:0] c);
    exp_t e;
    case (c)
      2'b01:   m_q = 1'b0;
      2'b10:   m_q = 1'b1;
      2'b11:   m_q = ~m_q;
      default: m_q = m_q;
    endcase
    e.id = id;
    e.q  = m_q;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; cmd_v = '0;
    repeat (3) tick();
    n_chk++; if (gnt !== '0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    n_chk++; if (j !== 1'b0) begin n_fail++; $display("FAIL rst_j: got %b want 0", j); end
    n_chk++; if (k !== 1'b0) begin n_fail++; $display("FAIL rst_k: got %b want 0", k); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_chk++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
    n_chk++; if (rsp_q !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_q: got %b want 0", rsp_q); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_set();
    exp_t e;
    cmd_v[0] = 2'b10; req = 4'b0001; push_exp(2'd0, 2'b10);
    tick();
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL set_gnt: got %b want 0001", gnt); end
    n_chk++; if ({j, k} !== 2'b10) begin n_fail++; $display("FAIL set_jk: got %b want 10", {j, k}); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL set_busy_drive: got %b want 1", busy); end
    req = '0;
    tick();
    n_chk++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL set_jk_sample: got %b want 00", {j, k}); end
    n_chk++; if (gnt !== '0) begin n_fail++; $display("FAIL set_gnt_sample: got %b want 0000", gnt); end
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL set_rsp_early: got %b want 0", rsp_valid); end
    tick();
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL set_rsp_valid: got %b want 1", rsp_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL set_busy_rsp: got %b want 0", busy); end
    if (sb.size() == 0) begin n_chk++; n_fail++; $display("FAIL set_sb: got a response with nothing queued, want queued entry"); end
    else begin
      e = sb.pop_front();
      n_chk++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL set_rsp_id: got %0d want %0d", rsp_id, e.id); end
      n_chk++; if (rsp_q !== e.q) begin n_fail++; $display("FAIL set_rsp_q: got %b want %b", rsp_q, e.q); end
    end
    tick();
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL set_rsp_pulse: got %b want 0", rsp_valid); end
  endtask

  task automatic test_toggle();
    exp_t e;
    logic exp_busy [6];
    int nrsp;
    exp_busy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    nrsp = 0;
    cmd_v[2] = 2'b11; req = 4'b0100;
    push_exp(2'd2, 2'b11); push_exp(2'd2, 2'b11);
    for (int c = 0; c < 6; c++) begin
      tick();
      n_chk++; if (busy !== exp_busy[c]) begin n_fail++; $display("FAIL tog_busy_c%0d: got %b want %b", c, busy, exp_busy[c]); end
      if (c == 0 || c == 3) begin
        n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL tog_gnt_c%0d: got %b want 0100", c, gnt); end
      end
      if (c == 3) req = '0;
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (sb.size() == 0) begin n_chk++; n_fail++; $display("FAIL tog_sb: got a response with nothing queued, want queued entry"); end
        else begin
          e = sb.pop_front();
          n_chk++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL tog_rsp_id: got %0d want %0d", rsp_id, e.id); end
          n_chk++; if (rsp_q !== e.q) begin n_fail++; $display("FAIL tog_rsp_q: got %b want %b", rsp_q, e.q); end
        end
      end
    end
    n_chk++; if (nrsp != 2) begin n_fail++; $display("FAIL tog_nrsp: got %0d want 2", nrsp); end
  endtask

  task automatic test_rr_order();
    exp_t e;
    logic [3:0] one;
    int g, last, nrsp;
    one = 4'b0001; g = 0; last = -1; nrsp = 0;
    rst_n = 1'b0; req = '0;
    tick();
    rst_n = 1'b1;
    cmd_v = {2'b00, 2'b11, 2'b10, 2'b01};
    push_exp(2'd0, 2'b01); push_exp(2'd1, 2'b10); push_exp(2'd2, 2'b11); push_exp(2'd3, 2'b00);
    req = 4'b1111;
    for (int c = 0; c < 20 && nrsp < 4; c++) begin
      tick();
      if (gnt !== '0) begin
        n_chk++; if (g >= 4 || gnt !== (one << g)) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", g, gnt, one << g); end
        if (last >= 0) begin
          n_chk++; if (c - last != 3) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d cycles want 3", g, c - last); end
        end
        last = c; req = req & ~gnt; g++;
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (sb.size() == 0) begin n_chk++; n_fail++; $display("FAIL rr_sb: got a response with nothing queued, want queued entry"); end
        else begin
          e = sb.pop_front();
          n_chk++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL rr_rsp_id: got %0d want %0d", rsp_id, e.id); end
          n_chk++; if (rsp_q !== e.q) begin n_fail++; $display("FAIL rr_rsp_q: got %b want %b", rsp_q, e.q); end
        end
      end
    end
    n_chk++; if (g != 4) begin n_fail++; $display("FAIL rr_ngrants: got %0d want 4", g); end
    n_chk++; if (nrsp != 4) begin n_fail++; $display("FAIL rr_nrsp: got %0d want 4", nrsp); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rr_err: got %b want 0", err); end
  endtask

  task automatic test_rr_ptr3();
    exp_t e;
    logic [3:0] want [2];
    int g, nrsp;
    logic done;
    want = '{4'b0010, 4'b0100};
    done = 1'b0;
    cmd_v[2] = 2'b00; req = 4'b0100; push_exp(2'd2, 2'b00);
    for (int c = 0; c < 10 && !done; c++) begin
      tick();
      if (gnt !== '0) begin
        n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL p3_pre_gnt: got %b want 0100", gnt); end
        req = '0;
      end
      if (rsp_valid === 1'b1) begin
        done = 1'b1;
        e = sb.pop_front();
        n_chk++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL p3_pre_id: got %0d want %0d", rsp_id, e.id); end
      end
    end
    n_chk++; if (!done) begin n_fail++; $display("FAIL p3_pre_timeout: got no response want one within 10 cycles"); end
    g = 0; nrsp = 0;
    cmd_v[1] = 2'b10; cmd_v[2] = 2'b01;
    push_exp(2'd1, 2'b10); push_exp(2'd2, 2'b01);
    req = 4'b0110;
    for (int c = 0; c < 12 && nrsp < 2; c++) begin
      tick();
      if (gnt !== '0) begin
        n_chk++; if (g >= 2 || gnt !== want[g % 2]) begin n_fail++; $display("FAIL p3_gnt%0d: got %b want %b", g, gnt, want[g % 2]); end
        req = req & ~gnt; g++;
      end
      if (rsp_valid === 1'b1) begin
        nrsp++;
        if (sb.size() == 0) begin n_chk++; n_fail++; $display("FAIL p3_sb: got a response with nothing queued, want queued entry"); end
        else begin
          e = sb.pop_front();
          n_chk++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL p3_rsp_id: got %0d want %0d", rsp_id, e.id); end
          n_chk++; if (rsp_q !== e.q) begin n_fail++; $display("FAIL p3_rsp_q: got %b want %b", rsp_q, e.q); end
        end
      end
    end
    n_chk++; if (nrsp != 2) begin n_fail++; $display("FAIL p3_nrsp: got %0d want 2", nrsp); end
  endtask

  task automatic test_reset_drive();
    exp_t e;
    int seen;
    seen = 0;
    cmd_v[1] = 2'b10; req = 4'b0010;
    tick();
    n_chk++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rd_gnt: got %b want 0010", gnt); end
    rst_n = 1'b0;
    #1;
    n_chk++; if ({j, k} !== 2'b00) begin n_fail++; $display("FAIL rd_jk: got %b want 00", {j, k}); end
    n_chk++; if (gnt !== '0) begin n_fail++; $display("FAIL rd_gnt_clr: got %b want 0000", gnt); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy: got %b want 0", busy); end
    req = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (rsp_valid !== 1'b0) seen++;
    end
    n_chk++; if (seen != 0) begin n_fail++; $display("FAIL rd_no_rsp: got %0d responses want 0", seen); end
    cmd_v[0] = 2'b10; cmd_v[3] = 2'b11; req = 4'b1001;
    push_exp(2'd0, 2'b10);
    tick();
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rd_first_gnt: got %b want 0001", gnt); end
    req = '0;
    repeat (2) tick();
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_valid: got %b want 1", rsp_valid); end
    else if (sb.size() != 0) begin
      e = sb.pop_front();
      n_chk++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL rd_rsp_id: got %0d want %0d", rsp_id, e.id); end
      n_chk++; if (rsp_q !== e.q) begin n_fail++; $display("FAIL rd_rsp_q: got %b want %b", rsp_q, e.q); end
    end
  endtask

  task automatic test_err();
    logic exp_err;
`ifdef JKFF_ARB_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    stuck = 1'b1;
    cmd_v[0] = 2'b10; req = 4'b0001;
    tick();
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL err_gnt: got %b want 0001", gnt); end
    req = '0;
    tick();
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b want 0", err); end
    tick();
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL err_rsp_valid: got %b want 1", rsp_valid); end
    n_chk++; if (rsp_q !== 1'b0) begin n_fail++; $display("FAIL err_rsp_q: got %b want 0", rsp_q); end
    n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL err_flag: got %b want %b", err, exp_err); end
    repeat (3) tick();
    n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL err_sticky: got %b want %b", err, exp_err); end
    stuck = 1'b0;
    m_q = 1'b1;
    rst_n = 1'b0;
    #1;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_rst: got %b want 0", err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle();
    test_rr_order();
    test_rr_ptr3();
    test_reset_drive();
    test_err();
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
